// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issue controller: decodes one RV32I instruction per handshake,
// drives the external combinational ALU, registers its result and resolves branches.
module alu_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_branch_taken,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110, ALU_SRA = 4'b0111, ALU_OR = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OP_R     = 7'b0110011, OP_I     = 7'b0010011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [3:0]        alu_control_q, alu_control_d;
  logic              illegal_q, illegal_d, is_branch_q, is_branch_d;
  logic [2:0]        br_f3_q, br_f3_d;
  logic              out_valid_q, out_valid_d, out_taken_q, out_taken_d, out_illegal_q, out_illegal_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;

  logic [3:0]        dec_ctrl;
  logic [XLEN-1:0]   dec_a, dec_b;
  logic              dec_illegal, dec_branch, accept, branch_cond;

  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        dec_ctrl = arith_ctrl(funct3, funct7_5);
      end
      OP_I: begin
        // Only the shift-right pair uses funct7_5; ADDI never becomes SUB.
        dec_a    = rs1_data;
        dec_b    = imm;
        dec_ctrl = arith_ctrl(funct3, funct7_5 & (funct3 == 3'b101));
      end
      OP_BRANCH: begin
        dec_a      = rs1_data;
        dec_b      = rs2_data;
        dec_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = ALU_SUB;
          3'b100, 3'b101: dec_ctrl = ALU_SLT;
          3'b110, 3'b111: dec_ctrl = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      OP_LUI:            dec_b = imm;
      OP_AUIPC: begin
        dec_a = pc;
        dec_b = imm;
      end
      OP_LOAD, OP_STORE: begin
        dec_a = rs1_data;
        dec_b = imm;
      end
      default:           dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_ctrl   = ALU_ADD;
      dec_branch = 1'b0;
    end
  end

  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    branch_cond = 1'b0;
    case (br_f3_q)
      3'b000:         branch_cond = zero;
      3'b001:         branch_cond = !zero;
      3'b100, 3'b110: branch_cond = alu_result[0];
      3'b101, 3'b111: branch_cond = !alu_result[0];
      default:        branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    alu_control_d = alu_control_q;
    illegal_d     = illegal_q;
    is_branch_d   = is_branch_q;
    br_f3_d       = br_f3_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        state_d       = DONE;
        out_valid_d   = 1'b1;
        out_result_d  = illegal_q ? '0 : alu_result;
        out_taken_d   = is_branch_q && branch_cond;
        out_illegal_d = illegal_q;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = in_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      operand_a_d   = dec_a;
      operand_b_d   = dec_b;
      alu_control_d = dec_ctrl;
      illegal_d     = dec_illegal;
      is_branch_d   = dec_branch;
      br_f3_d       = funct3;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      alu_control_q <= ALU_ADD;
      illegal_q     <= 1'b0;
      is_branch_q   <= 1'b0;
      br_f3_q       <= 3'b000;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      alu_control_q <= alu_control_d;
      illegal_q     <= illegal_d;
      is_branch_q   <= is_branch_d;
      br_f3_q       <= br_f3_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign operand_a        = operand_a_q;
  assign operand_b        = operand_b_q;
  assign alu_control      = alu_control_q;
  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign out_branch_taken = out_taken_q;
  assign out_illegal      = out_illegal_q;

endmodule
